// File: rtl/mux3_sel_pkg.sv
// Shared types and select encoding for the mux3_1 round-robin select controller.
// The mux maps 01->in[2], 10->in[1], 11->in[0]; 00 is the unused leg driven only when idle.
package mux3_sel_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_IN2  = 2'b01;
    localparam logic [1:0] SEL_IN1  = 2'b10;
    localparam logic [1:0] SEL_IN0  = 2'b11;

    function automatic logic [1:0] idx2sel(input logic [1:0] idx);
        logic [1:0] code;
        case (idx)
            2'd0:    code = SEL_IN0;
            2'd1:    code = SEL_IN1;
            2'd2:    code = SEL_IN2;
            default: code = SEL_NONE;
        endcase
        return code;
    endfunction

    // Grant is one-hot or zero, so a simple priority decode is exact.
    function automatic logic [1:0] onehot2idx(input logic [2:0] oh);
        logic [1:0] idx;
        if (oh[2])      idx = 2'd2;
        else if (oh[1]) idx = 2'd1;
        else            idx = 2'd0;
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker for three requesters.
// Search order starts one past the previous winner and wraps modulo 3.
module rr_pick3
    import mux3_sel_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last_winner,
    output logic [2:0] winner,
    output logic [1:0] winner_idx
);

    logic [1:0] first_idx;
    logic [1:0] second_idx;
    logic [1:0] third_idx;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        first_idx  = 2'd0;
        second_idx = 2'd1;
        third_idx  = 2'd2;
        case (last_winner)
            2'd0: begin
                first_idx  = 2'd1;
                second_idx = 2'd2;
                third_idx  = 2'd0;
            end
            2'd1: begin
                first_idx  = 2'd2;
                second_idx = 2'd0;
                third_idx  = 2'd1;
            end
            default: ;
        endcase
    end

    always_comb begin
        winner     = 3'b000;
        winner_idx = 2'd0;
        if (req[first_idx]) begin
            winner_idx = first_idx;
            winner     = 3'b001 << first_idx;
        end else if (req[second_idx]) begin
            winner_idx = second_idx;
            winner     = 3'b001 << second_idx;
        end else if (req[third_idx]) begin
            winner_idx = third_idx;
            winner     = 3'b001 << third_idx;
        end
    end

endmodule

// File: rtl/mux3_rr_sel_ctrl.sv
// Round-robin select controller driving mux3_1.select with a burst-holding grant.
// Holds the FSM, beat counter, last-winner pointer and all registered outputs.
module mux3_rr_sel_ctrl
    import mux3_sel_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic [2:0] last,
    input  logic       out_ready,
    output logic [1:0] select,
    output logic [2:0] grant,
    output logic       out_valid,
    output logic       busy
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

    state_e           state_q,       state_d;
    logic [2:0]       grant_q,       grant_d;
    logic [1:0]       select_q,      select_d;
    logic             busy_q,        busy_d;
    logic [CNT_W-1:0] beat_cnt_q,    beat_cnt_d;
    logic [1:0]       last_winner_q, last_winner_d;

    logic [2:0]       pick_oh;
    logic [1:0]       pick_idx;
    logic             owner_req;
    logic             owner_last;
    logic             xfer;
    logic [CNT_W-1:0] beat_cnt_inc;

    rr_pick3 u_pick (
        .req         (req),
        .last_winner (last_winner_q),
        .winner      (pick_oh),
        .winner_idx  (pick_idx)
    );

    assign owner_req    = |(req & grant_q);
    assign owner_last   = |(last & grant_q);
    assign out_valid    = owner_req;
    assign xfer         = owner_req & out_ready;
    assign beat_cnt_inc = beat_cnt_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        select_d      = select_q;
        busy_d        = busy_q;
        beat_cnt_d    = beat_cnt_q;
        last_winner_d = last_winner_q;
        case (state_q)
            IDLE: begin
                if (req != 3'b000) begin
                    state_d    = GRANT;
                    grant_d    = pick_oh;
                    select_d   = idx2sel(pick_idx);
                    busy_d     = 1'b1;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                // Abandon, last beat and hold limit all collapse into one release.
                if (!owner_req || (xfer && (owner_last || beat_cnt_inc == HOLD_LIM))) begin
                    state_d       = IDLE;
                    grant_d       = 3'b000;
                    select_d      = SEL_NONE;
                    busy_d        = 1'b0;
                    beat_cnt_d    = '0;
                    last_winner_d = onehot2idx(grant_q);
                end else if (xfer) begin
                    beat_cnt_d = beat_cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: reset is synchronous (only sampled on the clock edge), so rst_n is not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_q       <= 3'b000;
            select_q      <= SEL_NONE;
            busy_q        <= 1'b0;
            beat_cnt_q    <= '0;
            last_winner_q <= 2'd2;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            select_q      <= select_d;
            busy_q        <= busy_d;
            beat_cnt_q    <= beat_cnt_d;
            last_winner_q <= last_winner_d;
        end
    end

    assign select = select_q;
    assign grant  = grant_q;
    assign busy   = busy_q;

endmodule
